// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings for the data memory arbiter: FSM states and requester selects.
package arb_pkg;

   typedef enum logic {
      S_CPU = 1'b0,
      S_DMA = 1'b1
   } arb_state_e;

   typedef enum logic {
      SEL_CPU = 1'b0,
      SEL_DMA = 1'b1
   } arb_sel_e;

   // Bits needed to hold a counter value in 0..max.
   function automatic int unsigned cnt_width(input int unsigned max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle around the arbiter: CPU load/store side, DMA side, DataMemory side.
// slave = arbiter view, master = environment (CPU, DMA and memory) view.
interface data_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [2:0]        cpu_size;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              dma_req;
   logic              dma_lock;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic [2:0]        dma_size;
   logic              dma_gnt;
   logic [DATA_W-1:0] dma_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        mem_size;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
      output cpu_rdata, cpu_stall,
      input  dma_req, dma_lock, dma_we, dma_addr, dma_wdata, dma_size,
      output dma_gnt, dma_rdata,
      output mem_addr, mem_wdata, mem_size, mem_we, mem_re,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
      input  cpu_rdata, cpu_stall,
      output dma_req, dma_lock, dma_we, dma_addr, dma_wdata, dma_size,
      input  dma_gnt, dma_rdata,
      input  mem_addr, mem_wdata, mem_size, mem_we, mem_re,
      output mem_rdata
   );
endinterface

// File: rtl/data_mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module arb_sat_counter #(
   parameter int MAX = 4,
   parameter int W   = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);
   localparam logic [W-1:0] MAX_V = W'(MAX);

   // Count register: clear, else increment until MAX is reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX_V)) begin
         count <= count + W'(1);
      end
   end
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the DataMemory port between the CPU load/store path and a DMA requester.
// CPU has priority; DMA starvation bounded by MAX_WAIT, locked bursts by BURST_MAX.
//
//   state | meaning
//   S_CPU | normal arbitration: CPU wins unless DMA has waited MAX_WAIT cycles
//   S_DMA | locked DMA burst in progress: DMA owns the port while requesting
module data_mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_WAIT  = 4,
   parameter int BURST_MAX = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   data_mem_arbiter_if.slave   bus
);
   localparam int WAIT_W = cnt_width(MAX_WAIT);
   localparam int BEAT_W = cnt_width(BURST_MAX);
   localparam logic [WAIT_W-1:0] WAIT_MAX_V  = WAIT_W'(MAX_WAIT);
   localparam logic [BEAT_W-1:0] BURST_MAX_V = BEAT_W'(BURST_MAX);
   localparam bit BURST_EN = (BURST_MAX > 1);

   arb_state_e        state;
   arb_state_e        state_nxt;
   arb_sel_e          sel;
   logic              dma_win;
   logic              wait_inc;
   logic              beat_clr;
   logic [WAIT_W-1:0] wait_cnt;
   logic [BEAT_W-1:0] beat_cnt;
   logic [BEAT_W-1:0] beat_nxt;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [2:0]        sel_size;
   logic              sel_we;
   logic              sel_re;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_CPU;
      end else begin
         state <= state_nxt;
      end
   end

   // Grant decision and next state.
   always_comb begin
      dma_win   = 1'b0;
      state_nxt = state;
      beat_nxt  = beat_cnt + BEAT_W'(1);
      case (state)
         S_CPU: begin
            dma_win = bus.dma_req & (~bus.cpu_req | (wait_cnt == WAIT_MAX_V));
            if (dma_win && bus.dma_lock && BURST_EN) begin
               state_nxt = S_DMA;
            end
         end
         S_DMA: begin
            dma_win = bus.dma_req;
            if (!bus.dma_req || !bus.dma_lock || (beat_nxt == BURST_MAX_V)) begin
               state_nxt = S_CPU;
            end
         end
         default: state_nxt = S_CPU;
      endcase
   end

   // Staying in (or entering) S_DMA always means a granted beat, so beat_cnt
   // counts exactly while the burst lives and is cleared otherwise.
   assign beat_clr = (state_nxt == S_CPU);
   assign wait_inc = bus.dma_req & ~dma_win;

   arb_sat_counter #(.MAX(MAX_WAIT), .W(WAIT_W)) u_wait_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (~wait_inc),
      .inc   (wait_inc),
      .count (wait_cnt)
   );

   arb_sat_counter #(.MAX(BURST_MAX), .W(BEAT_W)) u_beat_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (beat_clr),
      .inc   (~beat_clr),
      .count (beat_cnt)
   );

   // Winner mux; with no DMA win the CPU side is selected even when idle.
   always_comb begin
      sel       = dma_win ? SEL_DMA : SEL_CPU;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
      sel_size  = bus.cpu_size;
      sel_we    = bus.cpu_req & bus.cpu_we;
      sel_re    = bus.cpu_req & ~bus.cpu_we;
      if (sel == SEL_DMA) begin
         sel_addr  = bus.dma_addr;
         sel_wdata = bus.dma_wdata;
         sel_size  = bus.dma_size;
         sel_we    = bus.dma_req & bus.dma_we;
         sel_re    = bus.dma_req & ~bus.dma_we;
      end
   end

   // Strobes are gated by rst_n so an asserted reset kills an in-flight beat at once.
   assign bus.mem_addr  = sel_addr;
   assign bus.mem_wdata = sel_wdata;
   assign bus.mem_size  = sel_size;
   assign bus.mem_we    = sel_we & rst_n;
   assign bus.mem_re    = sel_re & rst_n;
   assign bus.dma_gnt   = dma_win & rst_n;
   assign bus.cpu_stall = bus.cpu_req & dma_win & rst_n;
   assign bus.cpu_rdata = bus.mem_rdata;
   assign bus.dma_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter (MAX_WAIT=4, BURST_MAX=8) with a small
// combinational-read memory model behind the mem_* port.
module tb_data_mem_arbiter;
   import arb_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [31:0] mem [0:63];

   data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .BURST_MAX(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
   end

   typedef struct {
      logic        cr, cw;
      logic [31:0] ca, cd;
      logic        dr, dw;
      logic [31:0] da, dd;
      logic        e_gnt, e_stall, e_we, e_re;
      logic [31:0] e_addr;
      logic        chk_rd;
      logic [31:0] e_rd;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_req(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                          input logic dr, input logic dl, input logic dw,
                          input logic [31:0] da, input logic [31:0] dd);
      bus.cpu_req   = cr;
      bus.cpu_we    = cw;
      bus.cpu_addr  = ca;
      bus.cpu_wdata = cd;
      bus.cpu_size  = 3'b010;
      bus.dma_req   = dr;
      bus.dma_lock  = dl;
      bus.dma_we    = dw;
      bus.dma_addr  = da;
      bus.dma_wdata = dd;
      bus.dma_size  = 3'b010;
   endtask

   task automatic idle();
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;

      //                cr   cw      ca            cd       dr   dw      da            dd      gnt  stl  we   re      addr     chk         rd
      vecs[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h20, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 1'b0, 32'h0};
      vecs[3] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h12345678};
      vecs[4] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 1'b1, 32'h30, 32'h55,       1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'hDEADBEEF};
      vecs[5] = '{1'b0, 1'b1, 32'h44, 32'h77,       1'b0, 1'b1, 32'h30, 32'h55,       1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 1'b0, 32'h0};
      vecs[6] = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h12345678};

      // Reset: all strobes held low even with both requesters active.
      rst_n = 1'b0;
      set_req(1'b1, 1'b1, 32'h10, 32'h1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h2);
      #2;
      chk("rst_gnt", bus.dma_gnt, 1'b0);
      chk("rst_stall", bus.cpu_stall, 1'b0);
      chk("rst_we", bus.mem_we, 1'b0);
      chk("rst_re", bus.mem_re, 1'b0);
      chk("rst_state", 32'(dut.state), 32'(S_CPU));
      #20;
      idle();
      rst_n = 1'b1;
      next_cyc();

      // Single-cycle vectors.
      for (int v = 0; v < 7; v++) begin
         set_req(vecs[v].cr, vecs[v].cw, vecs[v].ca, vecs[v].cd,
                 vecs[v].dr, 1'b0, vecs[v].dw, vecs[v].da, vecs[v].dd);
         #2;
         chk($sformatf("v%0d_gnt", v), bus.dma_gnt, vecs[v].e_gnt);
         chk($sformatf("v%0d_stall", v), bus.cpu_stall, vecs[v].e_stall);
         chk($sformatf("v%0d_we", v), bus.mem_we, vecs[v].e_we);
         chk($sformatf("v%0d_re", v), bus.mem_re, vecs[v].e_re);
         chk($sformatf("v%0d_addr", v), bus.mem_addr, vecs[v].e_addr);
         if (vecs[v].chk_rd) begin
            if (vecs[v].e_gnt) chk($sformatf("v%0d_dma_rdata", v), bus.dma_rdata, vecs[v].e_rd);
            else               chk($sformatf("v%0d_cpu_rdata", v), bus.cpu_rdata, vecs[v].e_rd);
         end
         next_cyc();
      end
      idle();
      next_cyc();

      // Starvation bound: DMA forced through on the 5th contended cycle.
      for (int c = 1; c <= 6; c++) begin
         set_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
         #2;
         chk($sformatf("starve%0d_gnt", c), bus.dma_gnt, (c == 5));
         chk($sformatf("starve%0d_stall", c), bus.cpu_stall, (c == 5));
         chk($sformatf("starve%0d_addr", c), bus.mem_addr, (c == 5) ? 32'h20 : 32'h10);
         next_cyc();
      end
      idle();
      next_cyc();

      // Locked burst under CPU contention: 4 denied, 8 beats, 1 CPU cycle, re-arbitrate.
      for (int c = 1; c <= 14; c++) begin
         set_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 32'h80, 32'(c));
         #2;
         chk($sformatf("burst%0d_gnt", c), bus.dma_gnt, (c >= 5 && c <= 12));
         chk($sformatf("burst%0d_stall", c), bus.cpu_stall, (c >= 5 && c <= 12));
         if (c == 6)  chk("burst_state_dma", 32'(dut.state), 32'(S_DMA));
         if (c == 13) chk("burst_state_cpu", 32'(dut.state), 32'(S_CPU));
         next_cyc();
      end
      chk("burst_last_data", mem[32], 32'd12);
      idle();
      next_cyc();

      // Burst abandon after 3 locked beats.
      for (int c = 1; c <= 3; c++) begin
         set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
         #2;
         chk($sformatf("abandon%0d_gnt", c), bus.dma_gnt, 1'b1);
         next_cyc();
      end
      set_req(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
      #2;
      chk("abandon_state_dma", 32'(dut.state), 32'(S_DMA));
      chk("abandon_gnt", bus.dma_gnt, 1'b0);
      chk("abandon_stall", bus.cpu_stall, 1'b0);
      chk("abandon_we", bus.mem_we, 1'b1);
      next_cyc();
      set_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      chk("abandon_state_cpu", 32'(dut.state), 32'(S_CPU));
      chk("abandon_beat", 32'(dut.beat_cnt), 32'h0);
      chk("abandon_rdata", bus.cpu_rdata, 32'hA5A5A5A5);
      next_cyc();
      idle();
      next_cyc();

      // Reset in the middle of beat 2 of a locked write burst.
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h60, 32'h11111111);
      #2;
      chk("rburst1_gnt", bus.dma_gnt, 1'b1);
      next_cyc();
      set_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 32'h64, 32'h22222222);
      #1;
      chk("rburst2_gnt", bus.dma_gnt, 1'b1);
      chk("rburst2_stall", bus.cpu_stall, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rmid_gnt", bus.dma_gnt, 1'b0);
      chk("rmid_we", bus.mem_we, 1'b0);
      chk("rmid_stall", bus.cpu_stall, 1'b0);
      next_cyc();
      chk("rmid_state", 32'(dut.state), 32'(S_CPU));
      chk("rmid_wait", 32'(dut.wait_cnt), 32'h0);
      chk("rmid_beat", 32'(dut.beat_cnt), 32'h0);
      chk("rmid_beat1_mem", mem[24], 32'h11111111);
      chk("rmid_beat2_mem", mem[25], 32'h0);
      #2;
      rst_n = 1'b1;
      set_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      #1;
      chk("rpost_gnt", bus.dma_gnt, 1'b0);
      chk("rpost_stall", bus.cpu_stall, 1'b0);
      next_cyc();
      idle();
      next_cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
